// File: rtl/irq_sync_arbiter.sv
// irq_sync_arbiter: resynchronises IRQ_N async lines, latches edge/level pending bits, offers one line index on valid/ready.
// Latency: input captured at edge 1 -> pending after edge SYN_STAGE+1, irq_valid after edge SYN_STAGE+2; at most one grant per 2 cycles.
// Backpressure: an offer holds irq_valid/irq_id until irq_ready; other lines stay pending. `define IRQ_ARB_RR_EN for round-robin, else fixed lowest-index priority.
module irq_sync_arbiter #(
  parameter int  IRQ_N     = 8,
  parameter int  SYN_STAGE = 2,
  parameter real SIM_DELAY = 1.0,
  localparam int ID_W      = (IRQ_N > 1) ? $clog2(IRQ_N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IRQ_N-1:0] irq_in,
  input  logic [IRQ_N-1:0] irq_en,
  input  logic [IRQ_N-1:0] irq_edge,
  input  logic [IRQ_N-1:0] irq_clr,
  output logic [IRQ_N-1:0] irq_pending,
  output logic             irq_valid,
  output logic [ID_W-1:0]  irq_id,
  input  logic             irq_ready
);

  // Parameter sanity. SIM_DELAY is kept for interface compatibility with
  // behavioural models; register updates here are zero-delay.
  generate
    if (IRQ_N < 1 || IRQ_N > 32) begin : g_bad_irq_n
      $error("irq_sync_arbiter: IRQ_N must be 1..32");
    end
    if (SYN_STAGE < 1) begin : g_bad_syn_stage
      $error("irq_sync_arbiter: SYN_STAGE must be >= 1");
    end
    if (SIM_DELAY < 0.0) begin : g_bad_sim_delay
      $error("irq_sync_arbiter: SIM_DELAY must not be negative");
    end
  endgenerate

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_t;

  logic [IRQ_N-1:0] r_sync [SYN_STAGE];
  logic [IRQ_N-1:0] r_prev;
  logic [IRQ_N-1:0] r_pending;
  logic [ID_W-1:0]  r_id;
  state_t           r_state;

  logic [IRQ_N-1:0] w_sync;
  logic [IRQ_N-1:0] w_edge_set;
  logic [IRQ_N-1:0] w_edge_clr;
  logic [IRQ_N-1:0] w_hs_line;
  logic [IRQ_N-1:0] w_pend_nxt;
  logic [IRQ_N-1:0] w_elig;
  logic             w_any;
  logic             w_hs;
  logic             w_valid;
  logic             w_load;
  logic [ID_W-1:0]  w_win;
  state_t           w_state_nxt;

  assign w_sync = r_sync[SYN_STAGE-1];

  // Synchroniser chain per line plus the previous-value flop used for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYN_STAGE; k++) begin
        r_sync[k] <= '0;
      end
      r_prev <= '0;
    end else begin
      r_sync[0] <= irq_in;
      for (int k = 1; k < SYN_STAGE; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
      r_prev <= w_sync;
    end
  end

  // One-hot of the line whose offer completes this cycle.
  always_comb begin
    w_hs_line = '0;
    if (w_hs) begin
      w_hs_line[r_id] = 1'b1;
    end
  end

  // Edge lines: set beats clear. Level lines simply track the qualified sync value.
  assign w_edge_set = w_sync & ~r_prev & irq_en;
  assign w_edge_clr = irq_clr | w_hs_line;
  assign w_pend_nxt = (irq_edge & (w_edge_set | (r_pending & ~w_edge_clr)))
                    | (~irq_edge & w_sync & irq_en);

  // Pending register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pend_nxt;
    end
  end

  assign w_elig = r_pending & irq_en;
  assign w_any  = |w_elig;
  assign w_hs   = w_valid & irq_ready;

`ifdef IRQ_ARB_RR_EN
  logic [ID_W-1:0] r_last;
  int              w_best;

  // Round-robin pick: eligible line with the smallest forward distance from r_last+1.
  always_comb begin
    w_win  = '0;
    w_best = IRQ_N;
    for (int j = 0; j < IRQ_N; j++) begin
      if (w_elig[j] && (((j + IRQ_N - 1 - int'(r_last)) % IRQ_N) < w_best)) begin
        w_best = (j + IRQ_N - 1 - int'(r_last)) % IRQ_N;
        w_win  = ID_W'(j);
      end
    end
  end

  // Last-grant pointer advances only on a completed handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= '0;
    end else if (w_hs) begin
      r_last <= r_id;
    end
  end
`else
  // Fixed priority pick: scan downward so the lowest eligible index is written last.
  always_comb begin
    w_win = '0;
    for (int j = IRQ_N - 1; j >= 0; j--) begin
      if (w_elig[j]) begin
        w_win = ID_W'(j);
      end
    end
  end
`endif

  // Offer FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Offer FSM next state: once offering, only a handshake leaves OFFER.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_valid     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_load      = 1'b1;
          w_state_nxt = ST_OFFER;
        end
      end
      ST_OFFER: begin
        w_valid = 1'b1;
        if (irq_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  // Offered ID is captured when leaving IDLE and held for the whole offer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id <= '0;
    end else if (w_load) begin
      r_id <= w_win;
    end
  end

  assign irq_pending = r_pending;
  assign irq_valid   = w_valid;
  assign irq_id      = r_id;

endmodule

// File: tb/tb_irq_sync_arbiter.sv
// Bench for irq_sync_arbiter: directed scenarios then random traffic, checked against a queue-based reference model.
// Stimulus changes 1 time unit after each rising edge; the monitor samples on the falling edge.
// Expected grant IDs are queued when issued and popped by the monitor on each DUT handshake.
module tb_irq_sync_arbiter;
  localparam int IRQ_N = 8;
  localparam int SYN   = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] irq_in, irq_en, irq_edge, irq_clr, irq_pending;
  logic       irq_valid, irq_ready;
  logic [2:0] irq_id;

  always #5 clk = ~clk;

  irq_sync_arbiter #(.IRQ_N(IRQ_N), .SYN_STAGE(SYN), .SIM_DELAY(1.0)) dut (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .irq_en(irq_en),
    .irq_edge(irq_edge), .irq_clr(irq_clr), .irq_pending(irq_pending),
    .irq_valid(irq_valid), .irq_id(irq_id), .irq_ready(irq_ready)
  );

  // staged inputs for the coming cycle, and the inputs of the cycle just ended
  logic [7:0] t_in, t_en, t_edge, t_clr;
  logic       t_rdy, t_rst;
  logic [7:0] p_in, p_en, p_edge, p_clr;
  logic       p_rdy, p_rst;

  // reference model state (values visible after the latest edge)
  logic [7:0] m_pend;
  logic       m_valid;
  int         m_id;
  int         m_ptr;
  logic [7:0] m_hist[$];   // m_hist[0] = raw input sampled at the latest edge
  int         exp_q[$];

  int n_chk  = 0;
  int n_fail = 0;
  bit done   = 1'b0;

  task automatic model_reset();
    m_pend  = '0;
    m_valid = 1'b0;
    m_id    = 0;
    m_ptr   = 0;
    m_hist  = {};
    for (int k = 0; k <= SYN; k++) m_hist.push_back(8'h00);
  endtask

  function automatic int pick(input logic [7:0] elig, input int ptr);
    int w;
    w = -1;
`ifdef IRQ_ARB_RR_EN
    for (int k = 1; k <= IRQ_N; k++)
      if (w < 0 && elig[(ptr + k) % IRQ_N]) w = (ptr + k) % IRQ_N;
`else
    for (int k = 0; k < IRQ_N; k++)
      if (w < 0 && elig[k]) w = k;
`endif
    return w;
  endfunction

  // advance the model across one rising edge using the inputs of the cycle that just ended
  task automatic model_advance();
    logic [7:0] s, p, np;
    bit hs;
    if (!p_rst) begin
      model_reset();
      return;
    end
    s  = m_hist[SYN-1];
    p  = m_hist[SYN];
    hs = m_valid && p_rdy;
    for (int i = 0; i < IRQ_N; i++) begin
      if (p_edge[i]) begin
        if (s[i] && !p[i] && p_en[i])             np[i] = 1'b1;
        else if (p_clr[i] || (hs && m_id == i))   np[i] = 1'b0;
        else                                      np[i] = m_pend[i];
      end else begin
        np[i] = s[i] && p_en[i];
      end
    end
    if (m_valid) begin
      if (hs) begin
        m_valid = 1'b0;
        m_ptr   = m_id;
      end
    end else if ((m_pend & p_en) != 8'h00) begin
      m_id    = pick(m_pend & p_en, m_ptr);
      m_valid = 1'b1;
    end
    m_pend = np;
    m_hist.push_front(p_in);
    void'(m_hist.pop_back());
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_advance();
    irq_in = t_in; irq_en = t_en; irq_edge = t_edge; irq_clr = t_clr;
    irq_ready = t_rdy; rst_n = t_rst;
    if (!t_rst) model_reset();
    if (t_rst && m_valid && t_rdy) exp_q.push_back(m_id);
    p_in = t_in; p_en = t_en; p_edge = t_edge; p_clr = t_clr;
    p_rdy = t_rdy; p_rst = t_rst;
  endtask

  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // monitor: compares every cycle against the model and pops the scoreboard on handshakes
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (done) begin
        chk(exp_q.size() == 0, "grants_outstanding", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
      end
      chk(irq_pending == m_pend, "pending", int'(irq_pending), int'(m_pend));
      chk(irq_valid == m_valid, "valid", int'(irq_valid), int'(m_valid));
      if (irq_valid && irq_ready) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_grant", int'(irq_id), -1);
        end else begin
          e = exp_q.pop_front();
          chk(int'(irq_id) == e, "grant_id", int'(irq_id), e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no end of stimulus, expected finish");
    $fatal(1, "timeout");
  end

  // stimulus
  initial begin
    t_in = '0; t_en = '0; t_edge = '0; t_clr = '0; t_rdy = 1'b0; t_rst = 1'b0;
    irq_in = '0; irq_en = '0; irq_edge = '0; irq_clr = '0; irq_ready = 1'b0; rst_n = 1'b0;
    p_in = '0; p_en = '0; p_edge = '0; p_clr = '0; p_rdy = 1'b0; p_rst = 1'b0;
    model_reset();
    cyc(3);
    t_rst = 1'b1; t_en = 8'hFF; t_edge = 8'hFF;
    cyc(2);
    // latency: pulse line 3, hold offer with ready low, then one handshake
    t_in = 8'h08; cyc(3); t_in = 8'h00; cyc(5);
    t_rdy = 1'b1; cyc(1); t_rdy = 1'b0; cyc(4);
    // level line 5 re-requests with ready tied high, then drops
    t_edge = 8'hDF; t_in = 8'h20; t_rdy = 1'b1; cyc(10);
    t_in = 8'h00; cyc(6);
    // simultaneous edges on lines 1, 4, 6
    t_edge = 8'hFF; t_in = 8'h52; cyc(3); t_in = 8'h00; cyc(10);
    // offer stays stable under clear and disable of the offered line
    t_rdy = 1'b0; t_in = 8'h04; cyc(3); t_in = 8'h00; cyc(3);
    t_clr = 8'h04; t_en = 8'hFB; cyc(1); t_clr = 8'h00; cyc(3);
    t_rdy = 1'b1; cyc(1); t_rdy = 1'b0; t_en = 8'hFF;
    t_in = 8'h04; cyc(3); t_in = 8'h00; cyc(3); t_rdy = 1'b1; cyc(2);
    // reset while line 7 is offered, then quiet
    t_rdy = 1'b0; t_in = 8'h80; cyc(3); t_in = 8'h00; cyc(4);
    t_rst = 1'b0; cyc(2); t_rst = 1'b1; cyc(8);
    // random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < IRQ_N; i++)
        if ($urandom_range(0, 5) == 0) t_in[i] = ~t_in[i];
      if ($urandom_range(0, 49) == 0) t_edge = 8'($urandom);
      if ($urandom_range(0, 19) == 0) t_en = 8'($urandom) | 8'($urandom) | 8'($urandom);
      t_clr = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
      t_rdy = ($urandom_range(0, 2) != 0);
      t_rst = ($urandom_range(0, 499) != 0);
      tick();
    end
    t_rst = 1'b1; t_rdy = 1'b1; t_in = 8'h00; t_clr = 8'h00;
    cyc(10);
    done = 1'b1;
  end

endmodule
